// File: rtl/mio_arb_pkg.sv
// Shared types and constants for the two-master memory/IO bus arbiter.
package mio_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_CPU  = 2'b01;
  localparam logic [1:0] OWN_DMA  = 2'b10;

  // Wide enough for any supported DATA_W; the top slices what it needs.
  localparam logic [63:0] TIMEOUT_DATA = '1;

endpackage

// File: rtl/mio_arb_watchdog.sv
// Counts SERVE cycles without a slave ack; expire marks the TIMEOUT-th such cycle.
module mio_arb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + CW'(1);
    end
  end

  // Combinational so the FSM leaves SERVE right after the TIMEOUT-th cycle.
  assign expire = enable && (count == LAST);

endmodule

// File: rtl/mio_bus_arbiter.sv
// Round-robin arbiter sharing one memory/IO bus between the CPU and a DMA master.
// All outputs are registered; a slave that never acks is aborted by the watchdog.
module mio_bus_arbiter
  import mio_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ready,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic [1:0]        owner,
  output logic              timeout,
  output logic              err_flag
);

  localparam logic [DATA_W-1:0] TO_DATA = TIMEOUT_DATA[DATA_W-1:0];

  state_t            state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
  logic              cpu_ready_q, cpu_ready_d;
  logic              dma_ready_q, dma_ready_d;
  logic              timeout_q, timeout_d;
  logic              err_q, err_d;
  logic              last_dma_q, last_dma_d;
  logic              grant_dma;
  logic [DATA_W-1:0] rd_val;
  logic              wd_clear, wd_en, wd_expire;

  mio_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (wd_clear),
    .enable (wd_en),
    .expire (wd_expire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_NONE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      cpu_ready_q <= 1'b0;
      dma_ready_q <= 1'b0;
      timeout_q   <= 1'b0;
      err_q       <= 1'b0;
      last_dma_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
      cpu_ready_q <= cpu_ready_d;
      dma_ready_q <= dma_ready_d;
      timeout_q   <= timeout_d;
      err_q       <= err_d;
      last_dma_q  <= last_dma_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    cpu_ready_d = 1'b0;
    dma_ready_d = 1'b0;
    timeout_d   = 1'b0;
    err_d       = err_q;
    last_dma_d  = last_dma_q;
    wd_clear    = 1'b0;
    wd_en       = 1'b0;
    rd_val      = bus_ack ? bus_rdata : TO_DATA;
    // DMA wins when alone, or on a tie when the CPU was served last.
    grant_dma   = dma_req && (!cpu_req || !last_dma_q);

    unique case (state_q)
      IDLE: begin
        if (cpu_req || dma_req) begin
          state_d     = SERVE;
          owner_d     = grant_dma ? OWN_DMA : OWN_CPU;
          bus_req_d   = 1'b1;
          bus_we_d    = grant_dma ? dma_we : cpu_we;
          bus_addr_d  = grant_dma ? dma_addr : cpu_addr;
          bus_wdata_d = grant_dma ? dma_wdata : cpu_wdata;
          wd_clear    = 1'b1;
        end
      end
      SERVE: begin
        wd_en = 1'b1;
        if (bus_ack || wd_expire) begin
          state_d     = RESP;
          bus_req_d   = 1'b0;
          cpu_ready_d = (owner_q == OWN_CPU);
          dma_ready_d = (owner_q == OWN_DMA);
          // An aborted transaction still counts as a turn, so a dead slave cannot starve the peer.
          last_dma_d  = (owner_q == OWN_DMA);
          if (!bus_ack) begin
            timeout_d = 1'b1;
            err_d     = 1'b1;
          end
          if (!bus_we_q) begin
            if (owner_q == OWN_DMA) dma_rdata_d = rd_val;
            else                    cpu_rdata_d = rd_val;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
      default: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  assign cpu_rdata = cpu_rdata_q;
  assign cpu_ready = cpu_ready_q;
  assign dma_rdata = dma_rdata_q;
  assign dma_ready = dma_ready_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign owner     = owner_q;
  assign timeout   = timeout_q;
  assign err_flag  = err_q;

endmodule
